// File: rtl/frame_streamer_if.sv
// Control, frame-RAM read and video-output signals of frame_streamer.
// pattern_en exists only when FRAME_STREAMER_TEST_PATTERN_EN is defined.
interface frame_streamer_if;
   logic        start;
   logic        continuous;
   logic [10:0] in_width;
   logic [8:0]  in_height;
   logic        rd_en;
   logic [19:0] rd_addr;
   logic [23:0] rd_data;
   logic        vsync_out;
   logic        de_out;
   logic [23:0] pixel_out;
   logic        busy;
   logic        frame_done;
`ifdef FRAME_STREAMER_TEST_PATTERN_EN
   logic        pattern_en;
`endif

   modport master (
`ifdef FRAME_STREAMER_TEST_PATTERN_EN
      output pattern_en,
`endif
      output start, continuous, in_width, in_height, rd_data,
      input  rd_en, rd_addr, vsync_out, de_out, pixel_out, busy, frame_done
   );

   modport slave (
`ifdef FRAME_STREAMER_TEST_PATTERN_EN
      input  pattern_en,
`endif
      input  start, continuous, in_width, in_height, rd_data,
      output rd_en, rd_addr, vsync_out, de_out, pixel_out, busy, frame_done
   );
endinterface

// File: rtl/frame_streamer.sv
// Streams one frame (or back-to-back frames) from a linear frame RAM as vsync/de/pixel video.
// Optional FRAME_STREAMER_TEST_PATTERN_EN adds pattern_en, replacing RAM pixels with {col,row,8'h80}.
module frame_streamer #(
   parameter int V_SYNC_LEN = 4,
   parameter int V_BLANK    = 16,
   parameter int H_BLANK    = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   frame_streamer_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      VSYNC  = 3'd1,
      VBLANK = 3'd2,
      LINE   = 3'd3,
      HBLANK = 3'd4,
      DRAIN  = 3'd5
   } state_t;

   localparam logic [15:0] VS_LAST = 16'(V_SYNC_LEN - 1);
   localparam logic [15:0] VB_LAST = 16'(V_BLANK - 1);
   localparam logic [15:0] HB_LAST = 16'(H_BLANK - 1);

   state_t      state_r;
   logic [15:0] cnt_r;
   logic [10:0] col_r;
   logic [10:0] wid_r;
   logic [8:0]  row_r;
   logic [8:0]  hgt_r;
   logic [19:0] addr_r;
   logic        rd_act_r;
   logic        rd_en_r;
   logic        vsync_r;
   logic        busy_r;
   logic        done_r;
   logic        pat_r;
   logic        pat_s;
   logic        launch_ok_s;
   logic        de_p1_r;
   logic        pat_p1_r;
   logic [23:0] pix_p1_r;
   logic        de_r;
   logic [23:0] pix_r;

`ifdef FRAME_STREAMER_TEST_PATTERN_EN
   assign pat_s = bus.pattern_en;
`else
   assign pat_s = 1'b0;
`endif

   assign launch_ok_s = (bus.in_width != 11'd0) && (bus.in_height != 9'd0);

   // Frame sequencer: state, counters, read strobe and sync/status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         cnt_r    <= 16'd0;
         col_r    <= 11'd0;
         wid_r    <= 11'd0;
         row_r    <= 9'd0;
         hgt_r    <= 9'd0;
         addr_r   <= 20'd0;
         rd_act_r <= 1'b0;
         rd_en_r  <= 1'b0;
         vsync_r  <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         pat_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (bus.start && launch_ok_s) begin
                  wid_r   <= bus.in_width;
                  hgt_r   <= bus.in_height;
                  pat_r   <= pat_s;
                  col_r   <= 11'd0;
                  row_r   <= 9'd0;
                  addr_r  <= 20'd0;
                  cnt_r   <= 16'd0;
                  vsync_r <= 1'b1;
                  busy_r  <= 1'b1;
                  state_r <= VSYNC;
               end else begin
                  busy_r <= 1'b0;
               end
            end
            VSYNC: begin
               if (cnt_r == VS_LAST) begin
                  cnt_r   <= 16'd0;
                  vsync_r <= 1'b0;
                  state_r <= VBLANK;
               end else begin
                  cnt_r <= cnt_r + 16'd1;
               end
            end
            VBLANK: begin
               if (cnt_r == VB_LAST) begin
                  rd_act_r <= 1'b1;
                  rd_en_r  <= ~pat_r;
                  state_r  <= LINE;
               end else begin
                  cnt_r <= cnt_r + 16'd1;
               end
            end
            LINE: begin
               // Linear address simply keeps counting across line ends: row*width+col without a multiplier.
               addr_r <= addr_r + 20'd1;
               if (col_r == wid_r - 11'd1) begin
                  col_r    <= 11'd0;
                  cnt_r    <= 16'd0;
                  rd_act_r <= 1'b0;
                  rd_en_r  <= 1'b0;
                  state_r  <= (row_r == hgt_r - 9'd1) ? DRAIN : HBLANK;
               end else begin
                  col_r <= col_r + 11'd1;
               end
            end
            HBLANK: begin
               if (cnt_r == HB_LAST) begin
                  row_r    <= row_r + 9'd1;
                  rd_act_r <= 1'b1;
                  rd_en_r  <= ~pat_r;
                  state_r  <= LINE;
               end else begin
                  cnt_r <= cnt_r + 16'd1;
               end
            end
            DRAIN: begin
               // Two cycles cover the pixel pipeline; frame_done lands right after the last de_out.
               if (cnt_r == 16'd1) begin
                  done_r <= 1'b1;
                  cnt_r  <= 16'd0;
                  if (bus.continuous && launch_ok_s) begin
                     wid_r   <= bus.in_width;
                     hgt_r   <= bus.in_height;
                     pat_r   <= pat_s;
                     col_r   <= 11'd0;
                     row_r   <= 9'd0;
                     addr_r  <= 20'd0;
                     vsync_r <= 1'b1;
                     state_r <= VSYNC;
                  end else begin
                     busy_r  <= 1'b0;
                     state_r <= IDLE;
                  end
               end else begin
                  cnt_r <= cnt_r + 16'd1;
               end
            end
            default: begin
               rd_act_r <= 1'b0;
               rd_en_r  <= 1'b0;
               vsync_r  <= 1'b0;
               busy_r   <= 1'b0;
               state_r  <= IDLE;
            end
         endcase
      end
   end

   // Two-stage pixel pipeline matching the one-cycle RAM read latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         de_p1_r  <= 1'b0;
         pat_p1_r <= 1'b0;
         pix_p1_r <= 24'd0;
         de_r     <= 1'b0;
         pix_r    <= 24'd0;
      end else begin
         de_p1_r  <= rd_act_r;
         pat_p1_r <= pat_r;
         pix_p1_r <= {col_r[7:0], row_r[7:0], 8'h80};
         de_r     <= de_p1_r;
         if (!de_p1_r) begin
            pix_r <= 24'd0;
         end else if (pat_p1_r) begin
            pix_r <= pix_p1_r;
         end else begin
            pix_r <= bus.rd_data;
         end
      end
   end

   assign bus.rd_en      = rd_en_r;
   assign bus.rd_addr    = addr_r;
   assign bus.vsync_out  = vsync_r;
   assign bus.de_out     = de_r;
   assign bus.pixel_out  = pix_r;
   assign bus.busy       = busy_r;
   assign bus.frame_done = done_r;
endmodule
